// File: rtl/display_scan.sv
// Six-digit multiplexed 7-segment scanner with per-frame input snapshot,
// anti-ghost blanking at the start of each slot and hh.mm.ss separators.
module display_scan #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s_unidade,
  input  logic [3:0] s_dezena,
  input  logic [3:0] m_unidade,
  input  logic [3:0] m_dezena,
  input  logic [3:0] h_unidade,
  input  logic [3:0] h_dezena,
  input  logic       blank_lead,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned   CW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [2:0]    LAST_SLOT = 3'd5;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] snap_q, snap_d;
  logic [5:0][3:0] digits_in;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            fs_q, fs_d;

  logic            slot_end;
  logic            frame_end;
  logic            lead_blank;
  logic            dig_en;
  logic [3:0]      cur_dig;

  // Active-low gfedcba; anything outside 0..9 renders as a lone dash.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b0111111;
    endcase
  endfunction

  assign digits_in = {h_dezena, h_unidade, m_dezena, m_unidade, s_dezena, s_unidade};

  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (idx_q == LAST_SLOT);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = frame_end ? 3'd0 : idx_q + 3'd1;

    // Snapshot only at the frame boundary so a frame never mixes two times.
    snap_d = frame_end ? digits_in : snap_q;
    fs_d   = frame_end;

    case (idx_q)
      3'd0:    cur_dig = snap_q[0];
      3'd1:    cur_dig = snap_q[1];
      3'd2:    cur_dig = snap_q[2];
      3'd3:    cur_dig = snap_q[3];
      3'd4:    cur_dig = snap_q[4];
      3'd5:    cur_dig = snap_q[5];
      default: cur_dig = 4'd0;
    endcase

    // blank_lead is live; the zero test uses the snapshotted hours-tens.
    lead_blank = (idx_q == LAST_SLOT) && blank_lead && (snap_q[5] == 4'd0);
    dig_en     = (cnt_q >= BLANK_END) && !lead_blank && (idx_q <= LAST_SLOT);

    an_d  = dig_en ? ~(6'd1 << idx_q) : 6'h3F;
    seg_d = seg7(cur_dig);
    dp_d  = !(dig_en && ((idx_q == 3'd2) || (idx_q == 3'd4)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 3'd0;
      snap_q <= '0;
      an_q   <= 6'h3F;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      fs_q   <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: a frame-position model (global cycle count since
// reset) predicts every registered output; scenarios add direct checks.
module tb_display_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 6 * SD;

  logic       clk;
  logic       reset;
  logic [3:0] dig_in [6];
  logic       blank_lead;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  int n_cmp = 0;
  int n_err = 0;

  display_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_unidade   (dig_in[0]),
    .s_dezena    (dig_in[1]),
    .m_unidade   (dig_in[2]),
    .m_dezena    (dig_in[3]),
    .h_unidade   (dig_in[4]),
    .h_dezena    (dig_in[5]),
    .blank_lead  (blank_lead),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] segtab [16];
  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) segtab[i] = 7'b0111111;
  end

  // Reference: m_e counts non-reset edges; slot and in-slot cycle follow by division.
  int         m_e;
  logic [3:0] m_snap [6];
  logic [5:0] x_an;
  logic [6:0] x_seg;
  logic       x_dp, x_fs;
  int         m_c, m_s;
  bit         m_on;

  always @(posedge clk) begin
    if (reset) begin
      m_e = 0;
      for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
      x_an = 6'h3F; x_seg = 7'h7F; x_dp = 1'b1; x_fs = 1'b0;
    end else begin
      m_c  = m_e % SD;
      m_s  = (m_e / SD) % 6;
      m_on = (m_c >= BC) && !(m_s == 5 && blank_lead && m_snap[5] == 4'd0);
      x_an  = m_on ? ~(6'd1 << m_s) : 6'h3F;
      x_seg = segtab[m_snap[m_s]];
      x_dp  = !(m_on && (m_s == 2 || m_s == 4));
      x_fs  = (m_e % FRAME == FRAME - 1);
      if (m_e % FRAME == FRAME - 1)
        for (int i = 0; i < 6; i++) m_snap[i] = dig_in[i];
      m_e++;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    blank_lead = 1'b0;
    for (int i = 0; i < 6; i++) dig_in[i] = 4'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got an=%b seg=%b dp=%b fs=%b, want 111111 1111111 1 0",
               an, seg, dp, frame_start);
    end
  endtask

  task automatic test_scan_order();
    int order[$];
    int en_cnt [6];
    int k;
    bit seen;
    {dig_in[5], dig_in[4], dig_in[3], dig_in[2], dig_in[1], dig_in[0]} =
      {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    for (int i = 0; i < 6; i++) en_cnt[i] = 0;
    reset = 1'b0;
    seen = 0;
    for (int t = 0; t < 2 * FRAME && !seen; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL scan_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      seen = frame_start;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL scan_first_frame: frame_start=0, want 1 within budget"); end
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL scan_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      if (an != 6'h3F) begin
        k = 0;
        for (int b = 0; b < 6; b++) if (!an[b]) k = b;
        if (order.size() == 0 || order[$] != k) order.push_back(k);
        en_cnt[k]++;
        n_cmp++;
        if (seg !== segtab[dig_in[k]] || dp !== !(k == 2 || k == 4)) begin
          n_err++;
          $display("FAIL scan_digit slot=%0d: got seg=%b dp=%b, want seg=%b dp=%b",
                   k, seg, dp, segtab[dig_in[k]], !(k == 2 || k == 4));
        end
      end
    end
    n_cmp++;
    if (order.size() != 6) begin
      n_err++;
      $display("FAIL scan_order_len: got %0d slots, want 6", order.size());
    end else begin
      for (int i = 0; i < 6; i++) if (order[i] != i) begin
        n_err++;
        $display("FAIL scan_order pos=%0d: got slot %0d, want %0d", i, order[i], i);
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (en_cnt[i] != SD - BC) begin
        n_err++;
        $display("FAIL scan_enable_cycles digit=%0d: got %0d, want %0d", i, en_cnt[i], SD - BC);
      end
    end
  endtask

  task automatic test_anti_tearing();
    int hits;
    bit seen;
    for (int t = 0; t < 2 * FRAME && ((m_e / SD) % 6 != 3); t++) @(negedge clk);
    n_cmp++;
    if ((m_e / SD) % 6 != 3) begin n_err++; $display("FAIL tear_reach_slot3: got slot %0d, want 3", (m_e / SD) % 6); end
    dig_in[0] = 4'd7;
    seen = 0;
    for (int t = 0; t < 2 * FRAME && !seen; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL tear_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      seen = frame_start;
    end
    hits = 0;
    for (int t = 0; t < SD; t++) begin
      @(negedge clk);
      if (an == 6'b111110) begin
        hits++;
        n_cmp++;
        if (seg !== 7'b1111000) begin
          n_err++;
          $display("FAIL tear_new_value: got seg=%b, want 1111000", seg);
        end
      end
    end
    n_cmp++;
    if (hits != SD - BC) begin n_err++; $display("FAIL tear_slot0_cycles: got %0d, want %0d", hits, SD - BC); end
  endtask

  task automatic test_invalid_bcd();
    bit seen;
    dig_in[0] = 4'hC;
    seen = 0;
    for (int t = 0; t < 2 * FRAME && !seen; t++) begin @(negedge clk); seen = frame_start; end
    for (int t = 0; t < SD; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL bcd_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      if (an == 6'b111110) begin
        n_cmp++;
        if (seg !== 7'b0111111) begin n_err++; $display("FAIL bcd_dash: got seg=%b, want 0111111", seg); end
      end
    end
  endtask

  task automatic test_blank_lead();
    int hits;
    bit seen;
    dig_in[5] = 4'd0;
    blank_lead = 1'b1;
    seen = 0;
    for (int t = 0; t < 2 * FRAME && !seen; t++) begin @(negedge clk); seen = frame_start; end
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      n_cmp++;
      if (an[5] !== 1'b1 || {an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL blank_lead_on e=%0d: got an=%b seg=%b, want an=%b seg=%b",
                 m_e, an, seg, x_an, x_seg);
      end
    end
    blank_lead = 1'b0;
    hits = 0;
    for (int t = 0; t < FRAME; t++) begin
      @(negedge clk);
      if (an == 6'b011111) begin
        hits++;
        n_cmp++;
        if (seg !== 7'b1000000) begin n_err++; $display("FAIL blank_lead_off_seg: got %b, want 1000000", seg); end
      end
    end
    n_cmp++;
    if (hits != SD - BC) begin n_err++; $display("FAIL blank_lead_off_cycles: got %0d, want %0d", hits, SD - BC); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 5 * FRAME; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL rand_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin n_err++; $display("FAIL rand_onehot: got an=%b, want at most one low", an); end
      if ($urandom_range(7) == 0) dig_in[$urandom_range(5)] = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) blank_lead = ~blank_lead;
      if ($urandom_range(29) == 0) dig_in[5] = 4'd0;
    end
  endtask

  task automatic test_reset_mid();
    int first_fs;
    {dig_in[5], dig_in[4], dig_in[3], dig_in[2], dig_in[1], dig_in[0]} =
      {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    blank_lead = 1'b0;
    for (int t = 0; t < 2 * FRAME && (m_e % FRAME != 3 * SD + 5); t++) @(negedge clk);
    n_cmp++;
    if (m_e % FRAME != 3 * SD + 5) begin n_err++; $display("FAIL rmid_reach: got pos %0d, want %0d", m_e % FRAME, 3 * SD + 5); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({an, seg, dp, frame_start} !== {6'h3F, 7'h7F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rmid_reset_out: got an=%b seg=%b dp=%b fs=%b, want 111111 1111111 1 0",
               an, seg, dp, frame_start);
    end
    reset = 1'b0;
    first_fs = -1;
    for (int t = 1; t <= 2 * FRAME && first_fs < 0; t++) begin
      @(negedge clk);
      n_cmp++;
      if ({an, seg, dp, frame_start} !== {x_an, x_seg, x_dp, x_fs}) begin
        n_err++;
        $display("FAIL rmid_model e=%0d: got %b %b %b %b, want %b %b %b %b",
                 m_e, an, seg, dp, frame_start, x_an, x_seg, x_dp, x_fs);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin n_err++; $display("FAIL rmid_onehot: got an=%b, want at most one low", an); end
      if (an != 6'h3F) begin
        n_cmp++;
        if (seg !== 7'b1000000) begin n_err++; $display("FAIL rmid_zeros: got seg=%b, want 1000000", seg); end
      end
      if (frame_start) first_fs = t;
    end
    n_cmp++;
    if (first_fs != FRAME) begin n_err++; $display("FAIL rmid_first_capture: got cycle %0d, want %0d", first_fs, FRAME); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_anti_tearing();
    test_invalid_bcd();
    test_blank_lead();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
